// File: rtl/regfile_pkg.sv
// Shared constants for the register file: data width, address width,
// register count and the hard-wired zero register index.
package regfile_pkg;
  localparam int WIDTH    = 32;
  localparam int ADDR_W   = 5;
  localparam int NUM_REGS = 2 ** ADDR_W;
  localparam int ZERO_REG = 0;
endpackage

// File: rtl/regfile_decoder1to32.sv
// One-hot write-enable decoder: en gates the address into a single bit.
// Ports: en, addr[ADDR_W] in; onehot[2**ADDR_W] out (all-zero when en=0).
module decoder1to32 #(
  parameter int ADDR_W = 5
) (
  input  logic                 en,
  input  logic [ADDR_W-1:0]    addr,
  output logic [2**ADDR_W-1:0] onehot
);

  // Address is only looked at when en is high, so an unknown address
  // with en low still yields an all-zero vector.
  always_comb begin
    onehot = '0;
    if (en) begin
      onehot[addr] = 1'b1;
    end
  end

endmodule

// File: rtl/regfile.sv
// 2**ADDR_W x WIDTH register file, one write port, two combinational reads,
// r0 hard-wired to zero. Define REGFILE_BYPASS_EN for write-to-read forwarding.
// Ports: clk, reset_n (async, active-low), wr_en/wr_addr/wr_data,
//        rd_addr1/rd_data1, rd_addr2/rd_data2.
module regfile #(
  parameter int WIDTH  = regfile_pkg::WIDTH,
  parameter int ADDR_W = regfile_pkg::ADDR_W
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [WIDTH-1:0]  wr_data,
  input  logic [ADDR_W-1:0] rd_addr1,
  input  logic [ADDR_W-1:0] rd_addr2,
  output logic [WIDTH-1:0]  rd_data1,
  output logic [WIDTH-1:0]  rd_data2
);

  import regfile_pkg::*;

  localparam int NREGS = 2 ** ADDR_W;
  localparam logic [ADDR_W-1:0] ZADDR = ADDR_W'(ZERO_REG);

  logic [NREGS-1:0] we_vec;
  logic [WIDTH-1:0] regs_q [NREGS];
  logic [WIDTH-1:0] regs_d [NREGS];
  logic             byp1;
  logic             byp2;

  decoder1to32 #(
    .ADDR_W (ADDR_W)
  ) u_dec (
    .en     (wr_en),
    .addr   (wr_addr),
    .onehot (we_vec)
  );

  always_comb begin
    for (int i = 0; i < NREGS; i++) begin
      regs_d[i] = we_vec[i] ? wr_data : regs_q[i];
    end
    // r0 never loads, so it stays at its reset value of zero.
    regs_d[ZERO_REG] = '0;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < NREGS; i++) begin
        regs_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NREGS; i++) begin
        regs_q[i] <= regs_d[i];
      end
    end
  end

`ifdef REGFILE_BYPASS_EN
  // Forward the pending write, never to r0 and never during reset.
  always_comb begin
    byp1 = reset_n && wr_en && (wr_addr != ZADDR)
           && (wr_addr == rd_addr1);
    byp2 = reset_n && wr_en && (wr_addr != ZADDR)
           && (wr_addr == rd_addr2);
  end
`else
  always_comb begin
    byp1 = 1'b0;
    byp2 = 1'b0;
  end
`endif

  // Two 32:1 read muxes; registers are cleared during reset so the
  // outputs read zero then without extra gating.
  always_comb begin
    rd_data1 = byp1 ? wr_data : regs_q[rd_addr1];
    rd_data2 = byp2 ? wr_data : regs_q[rd_addr2];
  end

endmodule

// File: tb/tb_regfile.sv
// Self-checking bench for regfile: directed cases plus random traffic
// compared against an array model of the register contents.
module tb_regfile;

  logic        clk;
  logic        reset_n;
  logic        wr_en;
  logic [4:0]  wr_addr;
  logic [31:0] wr_data;
  logic [4:0]  rd_addr1;
  logic [4:0]  rd_addr2;
  logic [31:0] rd_data1;
  logic [31:0] rd_data2;

  logic [31:0] model [32];
  int n_chk;
  int n_pass;

`ifdef REGFILE_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  regfile dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .wr_en    (wr_en),
    .wr_addr  (wr_addr),
    .wr_data  (wr_data),
    .rd_addr1 (rd_addr1),
    .rd_addr2 (rd_addr2),
    .rd_data1 (rd_data1),
    .rd_data2 (rd_data2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_chk++;
    if (got === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] expect_rd(input logic [4:0] ra);
    if (!reset_n) return 32'h0;
    if (BYP && wr_en && wr_addr != 5'd0 && wr_addr == ra) return wr_data;
    if (ra == 5'd0) return 32'h0;
    return model[ra];
  endfunction

  task automatic clear_model();
    for (int i = 0; i < 32; i++) model[i] = 32'h0;
  endtask

  // Drive one cycle's inputs, check both reads before the edge,
  // then take the edge and update the model.
  task automatic step(input logic        we,
                      input logic [4:0]  wa,
                      input logic [31:0] wd,
                      input logic [4:0]  ra1,
                      input logic [4:0]  ra2,
                      input string       tag);
    @(negedge clk);
    wr_en    = we;
    wr_addr  = wa;
    wr_data  = wd;
    rd_addr1 = ra1;
    rd_addr2 = ra2;
    #1;
    check({tag, ".p1"}, rd_data1, expect_rd(ra1));
    check({tag, ".p2"}, rd_data2, expect_rd(ra2));
    @(posedge clk);
    if (we && reset_n && wa != 5'd0) model[wa] = wd;
  endtask

  initial begin
    n_chk    = 0;
    n_pass   = 0;
    reset_n  = 1'b0;
    wr_en    = 1'b0;
    wr_addr  = 5'd0;
    wr_data  = 32'h0;
    rd_addr1 = 5'd5;
    rd_addr2 = 5'd31;
    clear_model();

    #12;
    check("rst_p1", rd_data1, 32'h0);
    check("rst_p2", rd_data2, 32'h0);
    @(negedge clk);
    reset_n = 1'b1;

    // Basic write/read
    step(1'b1, 5'd7, 32'd123456789, 5'd7, 5'd8, "wr7");
    step(1'b0, 5'd0, 32'h0, 5'd7, 5'd8, "rd7");
    check("r7_val", rd_data1, 32'd123456789);
    check("r8_val", rd_data2, 32'h0);

    // Enable gating
    step(1'b0, 5'd7, 32'd666666, 5'd7, 5'd7, "gate_a");
    step(1'b0, 5'd7, 32'd666666, 5'd7, 5'd7, "gate_b");
    step(1'b0, 5'd0, 32'h0, 5'd7, 5'd0, "gate_c");
    check("r7_hold", rd_data1, 32'd123456789);
    step(1'b1, 5'd7, 32'd666666, 5'd7, 5'd1, "gate_w");
    step(1'b0, 5'd0, 32'h0, 5'd7, 5'd1, "gate_r");
    check("r7_new", rd_data1, 32'd666666);

    // Zero register
    step(1'b1, 5'd0, 32'hFFFFFFFF, 5'd0, 5'd0, "z_w");
    step(1'b0, 5'd0, 32'h0, 5'd0, 5'd0, "z_r");
    check("r0_p1", rd_data1, 32'h0);
    check("r0_p2", rd_data2, 32'h0);

    // Decoder sweep
    for (int i = 1; i < 32; i++) begin
      step(1'b1, 5'(i), 32'(i + 1), 5'(i), 5'd0, "sweep_w");
    end
    for (int i = 0; i < 32; i++) begin
      step(1'b0, 5'd0, 32'h0, 5'(i), 5'(31 - i), "sweep_r");
      check("sweep_abs", rd_data1, (i == 0) ? 32'h0 : 32'(i + 1));
    end

    // Bypass (r3 currently holds 4)
    @(negedge clk);
    wr_en    = 1'b1;
    wr_addr  = 5'd3;
    wr_data  = 32'd42;
    rd_addr1 = 5'd3;
    rd_addr2 = 5'd0;
    #1;
    check("byp_r3", rd_data1, BYP ? 32'd42 : 32'd4);
    check("byp_r0", rd_data2, 32'h0);
    @(posedge clk);
    model[3] = 32'd42;
    step(1'b0, 5'd0, 32'h0, 5'd3, 5'd3, "byp_after");

    // Unknown write address with enable low
    step(1'b0, 5'bx, 32'hBAD0BAD0, 5'd7, 5'd9, "xaddr");
    step(1'b0, 5'd0, 32'h0, 5'd7, 5'd9, "xaddr_r");

    // Random traffic
    for (int n = 0; n < 400; n++) begin
      step(1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)),
           $urandom(), 5'($urandom_range(0, 31)),
           5'($urandom_range(0, 31)), "rand");
    end

    // Async reset after writing r5
    step(1'b1, 5'd5, 32'hDEADBEEF, 5'd5, 5'd5, "r5_w");
    @(negedge clk);
    wr_en    = 1'b0;
    rd_addr1 = 5'd5;
    #1;
    check("r5_pre", rd_data1, 32'hDEADBEEF);
    reset_n = 1'b0;
    #1;
    check("r5_rst", rd_data1, 32'h0);
    clear_model();

    // Write attempted while reset held
    wr_en    = 1'b1;
    wr_addr  = 5'd9;
    wr_data  = 32'h12345678;
    rd_addr2 = 5'd9;
    #1;
    check("rst_byp", rd_data2, 32'h0);
    @(posedge clk);
    #1;
    check("rst_wr9", rd_data2, 32'h0);
    @(negedge clk);
    wr_en   = 1'b0;
    reset_n = 1'b1;
    step(1'b0, 5'd0, 32'h0, 5'd9, 5'd5, "post_rst");
    step(1'b1, 5'd9, 32'hA5A5A5A5, 5'd9, 5'd9, "post_w");
    step(1'b0, 5'd0, 32'h0, 5'd9, 5'd5, "post_r");

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end

endmodule

// File: doc/regfile.md
REGFILE -- requirements
Module: regfile

Interface
REQ-001 Parameter WIDTH, default 32, data width of each register and of each read/write port in bits.
REQ-002 Parameter ADDR_W, default 5, register address width; register count SHALL be 2**ADDR_W (32).
REQ-003 clk  input  1  the single clock; all state updates on its rising edge.
REQ-004 reset_n  input  1  reset, asynchronous and active-low.
REQ-005 wr_en  input  1  write enable; a write occurs only when high at a rising clk edge.
REQ-006 wr_addr  input  ADDR_W  destination register index.
REQ-007 wr_data  input  WIDTH  data written to wr_addr.
REQ-008 rd_addr1  input  ADDR_W  read port 1 register index.
REQ-009 rd_addr2  input  ADDR_W  read port 2 register index.
REQ-010 rd_data1  output  WIDTH  contents selected by rd_addr1.
REQ-011 rd_data2  output  WIDTH  contents selected by rd_addr2.

Function
REQ-012 Write path: wr_addr decoded one-hot, ANDed with wr_en; exactly one register's enable is asserted per write, none when wr_en=0.
REQ-013 Write latency: a register loads wr_data at the rising clk edge where its decoded enable is high; it holds its value on every other edge.
REQ-014 Register 0 SHALL always read 0; writes to address 0 have no effect and raise no error.
REQ-015 Read ports are combinational, zero-cycle latency: rd_dataN reflects the register selected by rd_addrN as of the most recent clk edge (subject to REQ-023).
REQ-016 Both read ports are independent; equal rd_addr1 and rd_addr2 return identical data.
REQ-017 Clock-high or clock-low levels without a rising edge SHALL NOT change any register.
REQ-018 Address inputs are full-range; no out-of-range case exists (all 2**ADDR_W indices valid).
REQ-019 X/Z on wr_addr while wr_en=0 SHALL NOT corrupt any register.

Reset
REQ-020 While reset_n=0, all registers SHALL be cleared to 0 immediately, independent of clk.
REQ-021 While reset_n=0, writes SHALL be ignored; rd_data1/rd_data2 SHALL read 0.
REQ-022 A rising clk edge on which reset_n is already 1 SHALL perform normal writes; reset asserting mid-write SHALL win and leave the target at 0.

Configuration
REQ-023 Macro REGFILE_BYPASS_EN: when defined, if wr_en=1 and wr_addr≠0 equals rd_addrN, rd_dataN SHALL return wr_data combinationally in the same cycle (write-to-read forwarding); when undefined, rd_dataN returns the old register value until the write edge.
REQ-024 Bypass SHALL never forward to address 0, nor while reset_n=0.

Structure
REQ-025 Shared package holds WIDTH, ADDR_W, NUM_REGS (2**ADDR_W) and ZERO_REG (0) constants.
REQ-026 One sub-module: decoder1to32, input enable and 5-bit address, output 32-bit one-hot enable vector; all-zero when enable=0.
REQ-027 Read selection implemented as two 32:1 WIDTH-bit multiplexers within regfile.

Verification
REQ-028 Reset: assert reset_n=0 after writing 32'hDEADBEEF to r5 -> rd_data1 (rd_addr1=5) reads 0 immediately, before any clk edge.
REQ-029 Write/read: wr_en=1, wr_addr=7, wr_data=123456789, one edge -> rd_data1=123456789 with rd_addr1=7; rd_data2=0 with rd_addr2=8.
REQ-030 Enable gating: wr_en=0, wr_addr=7, wr_data=666666, two edges -> r7 still 123456789; then wr_en=1, one edge -> 666666.
REQ-031 Zero register: write 32'hFFFFFFFF to address 0 -> rd_data1 and rd_data2 (both addr 0) read 0.
REQ-032 Decoder sweep: write value i+1 to each address i=1..31, then read all pairs -> each port returns i+1; no aliasing.
REQ-033 Bypass: wr_en=1, wr_addr=3, wr_data=42, rd_addr1=3 before edge -> rd_data1=42 with REGFILE_BYPASS_EN defined, previous r3 value without it.
